// File: rtl/fifo_word_unpacker.sv
// Read-side controller for fifo_hier: pops one word at a time and replays it as BEAT_W-bit valid/ready beats.
// Define UNPACK_MSB_FIRST_EN to emit the beats of each word MSB-first instead of LSB-first.
module fifo_word_unpacker #(
    parameter int WORD_W  = 64,
    parameter int BEAT_W  = 16,
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [WORD_W-1:0] fifo_data_out,
    input  logic              fifo_data_valid,
    output logic              pop_fifo,
    output logic [BEAT_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  words_drained,
    output logic              err
);

    localparam int BEATS = WORD_W / BEAT_W;
    localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TC_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);
    localparam logic [TC_W-1:0] LAST_TICK = TC_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_WAIT,
        S_SEND
    } state_t;

    state_t              r_state;
    logic [WORD_W-1:0]   r_holding;
    logic [BC_W-1:0]     r_beat;
    logic [TC_W-1:0]     r_timer;
    logic [CNT_W-1:0]    r_words_drained;
    logic                r_err;

    logic                w_more;
    logic                w_xfer;
    logic [BC_W-1:0]     w_sel;
    logic [BEAT_W-1:0]   w_beat_data;

    assign w_more = enable && !fifo_empty;
    assign w_xfer = (r_state == S_SEND) && out_ready;

`ifdef UNPACK_MSB_FIRST_EN
    assign w_sel = LAST_BEAT - r_beat;
`else
    assign w_sel = r_beat;
`endif

    // Constant-index mux keeps the slice selection free of variable part-selects.
    always_comb begin
        w_beat_data = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (w_sel == BC_W'(k)) begin
                w_beat_data = r_holding[k*BEAT_W +: BEAT_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
        if (reset) begin
            r_state         <= S_IDLE;
            // NOTE: the holding register is reset too, so out_data reads zero straight out of reset.
            r_holding       <= '0;
            r_beat          <= '0;
            r_timer         <= '0;
            r_words_drained <= '0;
            r_err           <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (fifo_data_valid) begin
                        r_err <= 1'b1;
                    end else if (w_more) begin
                        r_state <= S_POP;
                    end
                end
                S_POP: begin
                    if (fifo_data_valid) begin
                        r_holding <= fifo_data_out;
                        r_beat    <= '0;
                        r_state   <= S_SEND;
                    end else begin
                        r_timer <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (fifo_data_valid) begin
                        r_holding <= fifo_data_out;
                        r_beat    <= '0;
                        r_state   <= S_SEND;
                    end else if (r_timer == LAST_TICK) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TC_W'(1);
                    end
                end
                S_SEND: begin
                    // Valid with no pop outstanding is a protocol error; the word is ignored.
                    if (fifo_data_valid) begin
                        r_err <= 1'b1;
                    end
                    if (w_xfer) begin
                        if (r_beat == LAST_BEAT) begin
                            r_words_drained <= r_words_drained + CNT_W'(1);
                            r_state         <= w_more ? S_POP : S_IDLE;
                        end else begin
                            r_beat <= r_beat + BC_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pop_fifo      = (r_state == S_POP);
    assign out_valid     = (r_state == S_SEND);
    assign out_data      = w_beat_data;
    assign busy          = (r_state != S_IDLE);
    assign words_drained = r_words_drained;
    assign err           = r_err;

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Directed bench for fifo_word_unpacker with a small array-based model of the fifo_hier read port.
// Honours UNPACK_MSB_FIRST_EN when choosing the expected beat order.
module tb_fifo_word_unpacker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_empty;
    logic [63:0] fifo_data_out;
    logic        fifo_data_valid;
    logic        pop_fifo;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic [15:0] words_drained;
    logic        err;

    // FIFO model: tasks own tail and mem, the clocked block owns head and pop_cnt.
    logic [63:0] mem [16];
    int          head = 0;
    int          tail = 0;
    int          pop_cnt = 0;
    logic        auto_valid = 1'b1;
    logic        manual_valid = 1'b0;
    logic [63:0] manual_data = '0;

    int          n_vec = 0;
    int          n_miss = 0;

    logic [15:0] got_beat [32];
    int          got_cyc [32];
    int          got_n;
    int          stall_bad;

    fifo_word_unpacker #(
        .WORD_W (64),
        .BEAT_W (16),
        .TIMEOUT(8),
        .CNT_W  (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .fifo_empty     (fifo_empty),
        .fifo_data_out  (fifo_data_out),
        .fifo_data_valid(fifo_data_valid),
        .pop_fifo       (pop_fifo),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .busy           (busy),
        .words_drained  (words_drained),
        .err            (err)
    );

    always #5 clk = ~clk;

    assign fifo_empty      = (head == tail);
    assign fifo_data_out   = manual_valid ? manual_data : mem[head[3:0]];
    assign fifo_data_valid = manual_valid | (auto_valid & pop_fifo & ~fifo_empty);

    always @(posedge clk) begin
        if (pop_fifo) begin
            pop_cnt <= pop_cnt + 1;
            if (head != tail) head <= head + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] w);
        mem[tail[3:0]] = w;
        tail = tail + 1;
    endtask

    task automatic flush();
        tail = head;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Runs a fixed number of cycles, recording each beat that transfers and any stall violation.
    task automatic drain(input int cycles, input bit toggle);
        logic        pv;
        logic        pr;
        logic [15:0] pd;
        got_n = 0;
        stall_bad = 0;
        pv = 1'b0;
        pr = 1'b1;
        pd = '0;
        for (int c = 0; c < cycles; c++) begin
            if (pv && !pr && (out_valid !== 1'b1 || out_data !== pd)) stall_bad++;
            out_ready = toggle ? ((c % 2) == 0) : 1'b1;
            if (out_valid && out_ready && got_n < 32) begin
                got_beat[got_n] = out_data;
                got_cyc[got_n]  = c;
                got_n++;
            end
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
            step();
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        step();
        step();
        n_vec++; if (pop_fifo !== 1'b0) begin n_miss++; $display("FAIL reset_pop: got %b want 0", pop_fifo); end
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== 16'h0) begin n_miss++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (words_drained !== 16'd0) begin n_miss++; $display("FAIL reset_words: got %0d want 0", words_drained); end
        n_vec++; if (err !== 1'b0) begin n_miss++; $display("FAIL reset_err: got %b want 0", err); end
        reset = 1'b0;
    endtask

    task automatic test_single_word();
        logic [15:0] exp [4];
        int          p0;
`ifdef UNPACK_MSB_FIRST_EN
        exp[0] = 16'h1111; exp[1] = 16'h2222; exp[2] = 16'h3333; exp[3] = 16'h4444;
`else
        exp[0] = 16'h4444; exp[1] = 16'h3333; exp[2] = 16'h2222; exp[3] = 16'h1111;
`endif
        p0 = pop_cnt;
        push(64'h1111_2222_3333_4444);
        enable = 1'b1;
        out_ready = 1'b1;
        drain(12, 1'b0);
        n_vec++; if (got_n !== 4) begin n_miss++; $display("FAIL single_beats: got %0d want 4", got_n); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (got_beat[i] !== exp[i]) begin n_miss++; $display("FAIL single_beat%0d: got %h want %h", i, got_beat[i], exp[i]); end
        end
        n_vec++; if (got_cyc[3] - got_cyc[0] !== 3) begin n_miss++; $display("FAIL single_consecutive: got span %0d want 3", got_cyc[3] - got_cyc[0]); end
        n_vec++; if (pop_cnt - p0 !== 1) begin n_miss++; $display("FAIL single_pops: got %0d want 1", pop_cnt - p0); end
        n_vec++; if (words_drained !== 16'd1) begin n_miss++; $display("FAIL single_words: got %0d want 1", words_drained); end
        n_vec++; if (err !== 1'b0) begin n_miss++; $display("FAIL single_err: got %b want 0", err); end
    endtask

    task automatic test_back_to_back();
        int          p0;
        logic [15:0] wd0;
        logic [15:0] e;
        p0 = pop_cnt;
        wd0 = words_drained;
        enable = 1'b0;
        for (int k = 1; k <= 4; k++) push(64'h2222_2222_2222_2222 * k);
        enable = 1'b1;
        drain(60, 1'b1);
        n_vec++; if (got_n !== 16) begin n_miss++; $display("FAIL b2b_beats: got %0d want 16", got_n); end
        for (int i = 0; i < 16; i++) begin
            e = 16'(16'h2222 * (i / 4 + 1));
            n_vec++; if (got_beat[i] !== e) begin n_miss++; $display("FAIL b2b_beat%0d: got %h want %h", i, got_beat[i], e); end
        end
        n_vec++; if (stall_bad !== 0) begin n_miss++; $display("FAIL b2b_stall_hold: got %0d unstable cycles want 0", stall_bad); end
        n_vec++; if (pop_cnt - p0 !== 4) begin n_miss++; $display("FAIL b2b_pops: got %0d want 4", pop_cnt - p0); end
        n_vec++; if (words_drained !== wd0 + 16'd4) begin n_miss++; $display("FAIL b2b_words: got %0d want %0d", words_drained, wd0 + 16'd4); end
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_empty();
        int n_pop = 0;
        int n_busy = 0;
        int n_val = 0;
        flush();
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (pop_fifo) n_pop++;
            if (busy) n_busy++;
            if (out_valid) n_val++;
        end
        n_vec++; if (n_pop !== 0) begin n_miss++; $display("FAIL empty_pop: got %0d pulses want 0", n_pop); end
        n_vec++; if (n_busy !== 0) begin n_miss++; $display("FAIL empty_busy: got %0d cycles want 0", n_busy); end
        n_vec++; if (n_val !== 0) begin n_miss++; $display("FAIL empty_out_valid: got %0d cycles want 0", n_val); end
    endtask

    task automatic test_timeout();
        bit seen = 1'b0;
        int n = 0;
        int p0;
        enable = 1'b0;
        flush();
        auto_valid = 1'b0;
        push(64'h5555_6666_7777_8888);
        enable = 1'b1;
        for (int i = 0; i < 5 && !seen; i++) begin
            step();
            if (pop_fifo) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b1) begin n_miss++; $display("FAIL timeout_pop_seen: got %b want 1", seen); end
        for (int i = 0; i < 20 && err !== 1'b1; i++) begin
            step();
            n++;
        end
        // 8 cycles in WAIT, then the edge that returns to IDLE with err set.
        n_vec++; if (n !== 9) begin n_miss++; $display("FAIL timeout_cycles: got %0d want 9", n); end
        n_vec++; if (err !== 1'b1) begin n_miss++; $display("FAIL timeout_err: got %b want 1", err); end
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL timeout_idle: got busy %b want 0", busy); end
        p0 = pop_cnt;
        repeat (5) step();
        n_vec++; if (err !== 1'b1) begin n_miss++; $display("FAIL timeout_sticky: got %b want 1", err); end
        n_vec++; if (pop_cnt !== p0) begin n_miss++; $display("FAIL timeout_no_repop: got %0d pops want 0", pop_cnt - p0); end
        auto_valid = 1'b1;
        pulse_reset();
        n_vec++; if (err !== 1'b0) begin n_miss++; $display("FAIL timeout_err_cleared: got %b want 0", err); end
    endtask

    task automatic test_idle_valid();
        logic [15:0] wd0;
        int          n_val = 0;
        wd0 = words_drained;
        enable = 1'b0;
        flush();
        manual_data = 64'hab;
        manual_valid = 1'b1;
        step();
        manual_valid = 1'b0;
        n_vec++; if (err !== 1'b1) begin n_miss++; $display("FAIL idle_valid_err: got %b want 1", err); end
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL idle_valid_out_valid: got %b want 0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL idle_valid_busy: got %b want 0", busy); end
        repeat (3) begin
            step();
            if (out_valid) n_val++;
        end
        n_vec++; if (n_val !== 0) begin n_miss++; $display("FAIL idle_valid_later: got %0d valid cycles want 0", n_val); end
        n_vec++; if (words_drained !== wd0) begin n_miss++; $display("FAIL idle_valid_words: got %0d want %0d", words_drained, wd0); end
    endtask

    task automatic test_reset_mid_word();
        logic [15:0] exp1;
        logic [15:0] exp [4];
        bit          seen = 1'b0;
        int          p0;
`ifdef UNPACK_MSB_FIRST_EN
        exp1 = 16'hBEEF;
        exp[0] = 16'h0123; exp[1] = 16'h4567; exp[2] = 16'h89AB; exp[3] = 16'hCDEF;
`else
        exp1 = 16'hCAFE;
        exp[0] = 16'hCDEF; exp[1] = 16'h89AB; exp[2] = 16'h4567; exp[3] = 16'h0123;
`endif
        enable = 1'b0;
        pulse_reset();
        flush();
        push(64'hDEAD_BEEF_CAFE_F00D);
        push(64'h0123_4567_89AB_CDEF);
        out_ready = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b1) begin n_miss++; $display("FAIL midrst_first_beat_seen: got %b want 1", seen); end
        step();
        n_vec++; if (out_data !== exp1) begin n_miss++; $display("FAIL midrst_beat1: got %h want %h", out_data, exp1); end
        p0 = pop_cnt;
        reset = 1'b1;
        step();
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== 16'h0) begin n_miss++; $display("FAIL midrst_out_data: got %h want 0000", out_data); end
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_vec++; if (pop_fifo !== 1'b0) begin n_miss++; $display("FAIL midrst_pop: got %b want 0", pop_fifo); end
        n_vec++; if (words_drained !== 16'd0) begin n_miss++; $display("FAIL midrst_words: got %0d want 0", words_drained); end
        n_vec++; if (pop_cnt !== p0) begin n_miss++; $display("FAIL midrst_no_pop_on_reset: got %0d pops want 0", pop_cnt - p0); end
        reset = 1'b0;
        drain(12, 1'b0);
        n_vec++; if (got_n !== 4) begin n_miss++; $display("FAIL midrst_next_beats: got %0d want 4", got_n); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (got_beat[i] !== exp[i]) begin n_miss++; $display("FAIL midrst_next_beat%0d: got %h want %h", i, got_beat[i], exp[i]); end
        end
        n_vec++; if (words_drained !== 16'd1) begin n_miss++; $display("FAIL midrst_next_words: got %0d want 1", words_drained); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_empty();
        test_timeout();
        test_idle_valid();
        test_reset_mid_word();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
